// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared decode constants for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05
  } opcode_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int JT_HI  = 25;

  function automatic logic [5:0] get_op(input logic [31:0] w);
    return w[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] w);
    return w[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] w);
    return w[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// IF/ID-side bus: fetch inputs, ID operands, EX/MEM hazard info, PC controls.
interface fetch_redirect_ctrl_if #(
  parameter int B     = 32,
  parameter int CNT_W = 16
);
  logic [B-1:0]     if_instr;
  logic [B-1:0]     if_pc_incr;
  logic [B-1:0]     id_rs_data;
  logic [B-1:0]     id_rt_data;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic             disa;
  logic             pc_src;
  logic             jump;
  logic [B-1:0]     pc_branch;
  logic [B-1:0]     pc_jump;
  logic [B-1:0]     ifid_instr;
  logic [B-1:0]     ifid_pc_incr;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  if_instr, if_pc_incr, id_rs_data, id_rt_data,
           ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd,
    output disa, pc_src, jump, pc_branch, pc_jump, ifid_instr,
           ifid_pc_incr, idex_bubble, stall_count, flush_count
  );

  modport master (
    output if_instr, if_pc_incr, id_rs_data, id_rt_data,
           ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd,
    input  disa, pc_src, jump, pc_branch, pc_jump, ifid_instr,
           ifid_pc_incr, idex_bubble, stall_count, flush_count
  );
endinterface

// File: rtl/fetch_redirect_ctrl_hazard_detect.sv
// Combinational stall detection: load-use and branch operands not yet ready.
module hazard_detect
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  output logic       stall
);
  logic is_br, uses_rt, ex_hit_rs, ex_hit_rt, mem_hit;
  logic load_use, br_alu, br_load;

  // Branches compare in ID, so they need both operands from EX (ALU) or MEM (load).
  always_comb begin
    is_br     = (op == OP_BEQ) || (op == OP_BNE);
    uses_rt   = is_br || (op == OP_RTYPE);
    ex_hit_rs = (ex_rd != 5'd0) && (ex_rd == rs);
    ex_hit_rt = (ex_rd != 5'd0) && (ex_rd == rt);
    mem_hit   = (mem_rd != 5'd0) && ((mem_rd == rs) || (mem_rd == rt));
    load_use  = ex_mem_read && (ex_hit_rs || (uses_rt && ex_hit_rt));
    br_alu    = is_br && ex_reg_write && !ex_mem_read && (ex_hit_rs || ex_hit_rt);
    br_load   = is_br && mem_mem_read && mem_hit;
    stall     = valid && (load_use || br_alu || br_load);
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF/ID register, branch/jump decode in ID, PC control and stall/flush counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int B     = 32,
  parameter int CNT_W = 16
)(
  input  logic              clk,
  input  logic              reset,
  fetch_redirect_ctrl_if.slave bus
);
  logic [B-1:0]     instr_q, pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [5:0]   op;
  logic         is_beq, is_bne, is_jmp, taken, stall, redirect;
  logic [B-1:0] br_off;

  assign op = get_op(instr_q[31:0]);

  hazard_detect u_hz (
    .valid        (valid_q),
    .op           (op),
    .rs           (get_rs(instr_q[31:0])),
    .rt           (get_rt(instr_q[31:0])),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_reg_write (bus.ex_reg_write),
    .ex_rd        (bus.ex_rd),
    .mem_mem_read (bus.mem_mem_read),
    .mem_rd       (bus.mem_rd),
    .stall        (stall)
  );

  // ID decode and redirect resolution; a stall suppresses any redirect.
  always_comb begin
    is_beq   = valid_q && (op == OP_BEQ);
    is_bne   = valid_q && (op == OP_BNE);
    is_jmp   = valid_q && ((op == OP_J) || (op == OP_JAL));
    taken    = (is_beq && (bus.id_rs_data == bus.id_rt_data)) ||
               (is_bne && (bus.id_rs_data != bus.id_rt_data));
    redirect = !stall && (taken || is_jmp);
    br_off   = {{(B-18){instr_q[IMM_HI]}}, instr_q[IMM_HI:0], 2'b00};
  end

  assign bus.disa         = stall;
  assign bus.idex_bubble  = stall;
  assign bus.pc_src       = !stall && taken;
  assign bus.jump         = !stall && is_jmp;
  assign bus.pc_branch    = pc_q + br_off;
  assign bus.pc_jump      = {pc_q[B-1:B-4], instr_q[JT_HI:0], 2'b00};
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc_incr = pc_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

  // IF/ID register: hold on stall, kill wrong-path fetch on redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (stall) begin
      instr_q <= instr_q;
    end else if (redirect) begin
      instr_q <= B'(NOP);
      valid_q <= 1'b0;
      pc_q    <= bus.if_pc_incr;
    end else begin
      instr_q <= bus.if_instr;
      pc_q    <= bus.if_pc_incr;
      valid_q <= 1'b1;
    end
  end

  // Saturating stall/flush counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: vector table, corner sequences, random vs model.
module tb_fetch_redirect_ctrl;
  localparam int B  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.B(B), .CNT_W(CW)) bus();
  fetch_redirect_ctrl #(.B(B), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_instr, m_pc;
  bit          m_valid;
  int          m_ns, m_nf;
  bit          e_stall, e_src, e_jump;
  logic [31:0] e_br, e_jt;

  typedef struct {
    logic [31:0] instr, pc, rsd, rtd;
    logic        exmr, exrw;
    logic [4:0]  exrd;
    logic        memmr;
    logic [4:0]  memrd;
    logic        e_disa, e_src, e_jump;
    logic        ck_br, ck_jt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] sat(input int n);
    return (n > 65535) ? 32'd65535 : 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected combinational outputs, straight from the hazard/redirect rules
  task automatic model_comb();
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit br, urt, lu, ba, bl, tk;
    logic signed [31:0] off;
    op  = m_instr[31:26];
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    br  = (op == 6'h04) || (op == 6'h05);
    urt = br || (op == 6'h00);
    lu  = bus.ex_mem_read && bus.ex_rd != 0 && (bus.ex_rd == rs || (urt && bus.ex_rd == rt));
    ba  = br && bus.ex_reg_write && !bus.ex_mem_read && bus.ex_rd != 0 &&
          (bus.ex_rd == rs || bus.ex_rd == rt);
    bl  = br && bus.mem_mem_read && bus.mem_rd != 0 && (bus.mem_rd == rs || bus.mem_rd == rt);
    e_stall = m_valid && (lu || ba || bl);
    tk  = br && ((op == 6'h04) == (bus.id_rs_data == bus.id_rt_data));
    e_src  = m_valid && !e_stall && tk;
    e_jump = m_valid && !e_stall && (op == 6'h02 || op == 6'h03);
    off  = $signed(m_instr[15:0]);
    e_br = m_pc + 32'(off * 4);
    e_jt = (m_pc & 32'hF000_0000) | (32'(m_instr[25:0]) << 2);
  endtask

  task automatic model_check();
    model_comb();
    chk("m_disa", {31'd0, bus.disa}, {31'd0, e_stall});
    chk("m_bubble", {31'd0, bus.idex_bubble}, {31'd0, e_stall});
    chk("m_pc_src", {31'd0, bus.pc_src}, {31'd0, e_src});
    chk("m_jump", {31'd0, bus.jump}, {31'd0, e_jump});
    chk("m_pc_branch", bus.pc_branch, e_br);
    chk("m_pc_jump", bus.pc_jump, e_jt);
    chk("m_ifid_instr", bus.ifid_instr, m_instr);
    chk("m_ifid_pc", bus.ifid_pc_incr, m_pc);
    chk("m_stall_count", 32'(bus.stall_count), sat(m_ns));
    chk("m_flush_count", 32'(bus.flush_count), sat(m_nf));
  endtask

  task automatic model_edge();
    if (reset) begin
      m_instr = 0; m_pc = 0; m_valid = 0; m_ns = 0; m_nf = 0;
    end else if (e_stall) begin
      m_ns++;
    end else if (e_src || e_jump) begin
      m_instr = 0; m_valid = 0; m_pc = bus.if_pc_incr; m_nf++;
    end else begin
      m_instr = bus.if_instr; m_pc = bus.if_pc_incr; m_valid = 1;
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic set_idle();
    bus.if_instr = 0; bus.if_pc_incr = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_rd = 0;
    bus.mem_mem_read = 0; bus.mem_rd = 0;
  endtask

  task automatic add_vec(input logic [31:0] instr, pc, rsd, rtd, input logic exmr, exrw,
                         input logic [4:0] exrd, input logic memmr, input logic [4:0] memrd,
                         input logic ed, es, ej, cb, cj, input logic [31:0] tgt);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rsd = rsd; v.rtd = rtd; v.exmr = exmr; v.exrw = exrw;
    v.exrd = exrd; v.memmr = memmr; v.memrd = memrd; v.e_disa = ed; v.e_src = es;
    v.e_jump = ej; v.ck_br = cb; v.ck_jt = cj; v.e_tgt = tgt;
    vt.push_back(v);
  endtask

  logic [31:0] w_beq, w_bne, w_add;

  initial begin
    reset = 1'b1;
    set_idle();
    edge_();

    // vector table: {instr, pc, rs_data, rt_data, exmr, exrw, exrd, memmr, memrd, disa, src, jump, ck_br, ck_jt, target}
    add_vec({6'h02, 26'h0000100}, 32'h0040_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0400);
    add_vec(mk(6'h04, 1, 2, 16'hFFFE), 32'h100, 5, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'hF8);
    add_vec(mk(6'h04, 1, 2, 16'hFFFE), 32'h100, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hF8);
    add_vec(mk(6'h00, 8, 3, 16'h2020), 32'h40, 0, 0, 1, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(mk(6'h00, 8, 3, 16'h2020), 32'h40, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(mk(6'h00, 8, 3, 16'h2020), 32'h40, 0, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(mk(6'h08, 1, 8, 16'h0004), 32'h40, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(mk(6'h05, 9, 0, 16'h0004), 32'h40, 1, 2, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0);
    add_vec(mk(6'h04, 3, 4, 16'h0004), 32'h40, 1, 1, 0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    add_vec(mk(6'h04, 3, 4, 16'h0004), 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 32'h50);
    add_vec({6'h03, 26'h3FFFFFF}, 32'hF000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFC);
    add_vec(mk(6'h05, 1, 2, 16'h0002), 32'hFFFF_FFFC, 7, 8, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h4);
    add_vec(mk(6'h04, 0, 0, 16'h0001), 32'h200, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 32'h204);
    add_vec(mk(6'h04, 5, 6, 16'h0001), 32'h200, 0, 0, 1, 1, 6, 0, 0, 1, 0, 0, 0, 0, 0);

    // reset with a branch held at the fetch port
    w_beq = mk(6'h04, 1, 2, 16'h0003);
    bus.if_instr = w_beq; bus.if_pc_incr = 32'h44;
    cyc();
    half();
    chk("rst_ifid_instr", bus.ifid_instr, 0);
    chk("rst_ctrl", {29'd0, bus.disa, bus.pc_src, bus.jump}, 0);
    chk("rst_counts", {bus.stall_count, bus.flush_count}, 0);
    edge_();
    reset = 1'b0;
    cyc();
    half();
    chk("first_fetch", bus.ifid_instr, w_beq);
    chk("first_fetch_pc", bus.ifid_pc_incr, 32'h44);
    edge_();

    foreach (vt[i]) begin
      reset = 1'b1; set_idle(); cyc();
      reset = 1'b0;
      bus.if_instr = vt[i].instr; bus.if_pc_incr = vt[i].pc;
      cyc();
      bus.if_instr = 0; bus.if_pc_incr = vt[i].pc + 4;
      bus.id_rs_data = vt[i].rsd; bus.id_rt_data = vt[i].rtd;
      bus.ex_mem_read = vt[i].exmr; bus.ex_reg_write = vt[i].exrw; bus.ex_rd = vt[i].exrd;
      bus.mem_mem_read = vt[i].memmr; bus.mem_rd = vt[i].memrd;
      half();
      chk($sformatf("v%0d_ctrl", i), {28'd0, bus.disa, bus.idex_bubble, bus.pc_src, bus.jump},
          {28'd0, vt[i].e_disa, vt[i].e_disa, vt[i].e_src, vt[i].e_jump});
      if (vt[i].ck_br) chk($sformatf("v%0d_pc_branch", i), bus.pc_branch, vt[i].e_tgt);
      if (vt[i].ck_jt) chk($sformatf("v%0d_pc_jump", i), bus.pc_jump, vt[i].e_tgt);
      edge_();
      half();
      chk($sformatf("v%0d_ifid_next", i), bus.ifid_instr, vt[i].e_disa ? vt[i].instr : 32'h0);
      chk($sformatf("v%0d_counts", i), {bus.stall_count, bus.flush_count},
          {16'(vt[i].e_disa), 16'(vt[i].e_src || vt[i].e_jump)});
      edge_();
    end

    // branch after a load: EX match then MEM match, then resolves
    reset = 1'b1; set_idle(); cyc(); reset = 1'b0;
    w_bne = mk(6'h05, 9, 2, 16'h0004);
    bus.if_instr = w_bne; bus.if_pc_incr = 32'h80;
    cyc();
    bus.if_instr = mk(6'h00, 1, 1, 16'h0820); bus.if_pc_incr = 32'h84;
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = 9;
    half(); chk("lw_br_s1", {31'd0, bus.disa}, 1); edge_();
    bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_rd = 0;
    bus.mem_mem_read = 1; bus.mem_rd = 9;
    half(); chk("lw_br_s2", {31'd0, bus.disa}, 1); chk("lw_br_hold", bus.ifid_instr, w_bne); edge_();
    bus.mem_mem_read = 0; bus.mem_rd = 0; bus.id_rs_data = 1; bus.id_rt_data = 2;
    half();
    chk("lw_br_go", {30'd0, bus.disa, bus.pc_src}, 32'd1);
    chk("lw_br_stalls", 32'(bus.stall_count), 2);
    edge_();
    half(); chk("lw_br_flush", 32'(bus.flush_count), 1); edge_();

    // reset arriving mid-stall
    reset = 1'b1; set_idle(); cyc(); reset = 1'b0;
    w_add = mk(6'h00, 8, 3, 16'h2020);
    bus.if_instr = w_add; cyc();
    bus.ex_mem_read = 1; bus.ex_rd = 8;
    cyc();
    reset = 1'b1;
    half(); chk("mid_rst_noredir", {30'd0, bus.pc_src, bus.jump}, 0); edge_();
    half();
    chk("mid_rst_clear", bus.ifid_instr, 0);
    chk("mid_rst_cnt", 32'(bus.stall_count), 0);
    edge_();
    reset = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] ops[7];
      ops = '{6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h23};
      reset = ($urandom_range(0, 40) == 0);
      bus.if_instr = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 16'($urandom));
      bus.if_pc_incr = $urandom;
      bus.id_rs_data = $urandom_range(0, 2);
      bus.id_rt_data = $urandom_range(0, 2);
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.mem_mem_read = 1'($urandom_range(0, 1));
      bus.mem_rd = 5'($urandom_range(0, 3));
      cyc();
    end

    // counter saturation under a long load-use stall
    reset = 1'b1; set_idle(); cyc(); reset = 1'b0;
    bus.if_instr = w_add; cyc();
    bus.ex_mem_read = 1; bus.ex_rd = 8;
    half();
    repeat (65539) edge_();
    half();
    chk("stall_sat", 32'(bus.stall_count), 32'h0000_FFFF);
    edge_();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
